// File: rtl/ttc_param1.sv
// ttc_param1: APB timer/counter with NUM_CH channels (prescaler, up-counter, wrap/match, masked IRQs).
// Define TTC_ONE_SHOT_EN to make CTRL[3] a one-shot bit that clears en on the first wrap.
module ttc_param1 #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 16,
    parameter int PSC_W  = 8
) (
    input  logic              pclk1,
    input  logic              p_reset1,
    input  logic              psel1,
    input  logic              penable1,
    input  logic              pwrite1,
    input  logic [7:0]        paddr1,
    input  logic [31:0]       pwdata1,
    output logic [31:0]       prdata1,
    output logic [NUM_CH-1:0] interrupt1
);
`ifdef TTC_ONE_SHOT_EN
    localparam bit ONE_SHOT = 1'b1;
`else
    localparam bit ONE_SHOT = 1'b0;
`endif
    localparam int SW = 2 * NUM_CH;

    logic             en_q   [NUM_CH], en_d   [NUM_CH];
    logic             mode_q [NUM_CH], mode_d [NUM_CH];
    logic             men_q  [NUM_CH], men_d  [NUM_CH];
    logic             os_q   [NUM_CH], os_d   [NUM_CH];
    logic [PSC_W-1:0] psc_q  [NUM_CH], psc_d  [NUM_CH];
    logic [PSC_W-1:0] pcnt_q [NUM_CH], pcnt_d [NUM_CH];
    logic [CNT_W-1:0] ival_q [NUM_CH], ival_d [NUM_CH];
    logic [CNT_W-1:0] mat_q  [NUM_CH], mat_d  [NUM_CH];
    logic [CNT_W-1:0] cnt_q  [NUM_CH], cnt_d  [NUM_CH];
    logic [CNT_W-1:0] nxt    [NUM_CH];
    logic             tick   [NUM_CH], wrap   [NUM_CH];
    logic [SW-1:0]    sts_q, sts_d, ien_q, ien_d, set_ev;
    logic             wr, rd, unused_wdata;

    assign wr = psel1 & penable1 & pwrite1;
    assign rd = psel1 & ~pwrite1;
    assign unused_wdata = ^pwdata1;

    always_comb begin
        prdata1 = '0;
        set_ev  = '0;
        ien_d   = (wr && paddr1 == 8'h84) ? pwdata1[SW-1:0] : ien_q;
        for (int c = 0; c < NUM_CH; c++) begin
            en_d[c]   = en_q[c];
            mode_d[c] = mode_q[c];
            men_d[c]  = men_q[c];
            os_d[c]   = os_q[c];
            psc_d[c]  = psc_q[c];
            ival_d[c] = ival_q[c];
            mat_d[c]  = mat_q[c];
            cnt_d[c]  = cnt_q[c];
            tick[c]   = en_q[c] && pcnt_q[c] == psc_q[c];
            // An interval set below COUNT is missed; the all-ones rollover then wraps without an event.
            wrap[c]   = mode_q[c] ? cnt_q[c] == ival_q[c] : &cnt_q[c];
            nxt[c]    = (wrap[c] || &cnt_q[c]) ? '0 : cnt_q[c] + CNT_W'(1);
            pcnt_d[c] = (en_q[c] && !tick[c]) ? pcnt_q[c] + PSC_W'(1) : '0;
            if (tick[c]) begin
                cnt_d[c]        = nxt[c];
                set_ev[2*c]     = wrap[c];
                set_ev[2*c+1]   = men_q[c] && nxt[c] == mat_q[c];
                if (wrap[c] && os_q[c]) en_d[c] = 1'b0;
            end
            if (wr && paddr1[7:4] == 4'(c)) begin
                if (paddr1[3:0] == 4'h0) begin
                    en_d[c]   = pwdata1[0];
                    mode_d[c] = pwdata1[1];
                    men_d[c]  = pwdata1[2];
                    os_d[c]   = ONE_SHOT & pwdata1[3];
                    psc_d[c]  = pwdata1[16 +: PSC_W];
                    if (pwdata1[8]) begin
                        cnt_d[c]        = '0;
                        pcnt_d[c]       = '0;
                        set_ev[2*c +: 2] = 2'b00;
                    end
                end
                if (paddr1[3:0] == 4'h4) ival_d[c] = pwdata1[CNT_W-1:0];
                if (paddr1[3:0] == 4'h8) mat_d[c] = pwdata1[CNT_W-1:0];
            end
            if (rd && paddr1[7:4] == 4'(c)) begin
                if (paddr1[3:0] == 4'h0) begin
                    prdata1[0]          = en_q[c];
                    prdata1[1]          = mode_q[c];
                    prdata1[2]          = men_q[c];
                    prdata1[3]          = os_q[c];
                    prdata1[16 +: PSC_W] = psc_q[c];
                end
                if (paddr1[3:0] == 4'h4) prdata1[CNT_W-1:0] = ival_q[c];
                if (paddr1[3:0] == 4'h8) prdata1[CNT_W-1:0] = mat_q[c];
                if (paddr1[3:0] == 4'hC) prdata1[CNT_W-1:0] = cnt_q[c];
            end
        end
        // New events override a same-cycle W1C of the same bit.
        sts_d = ((wr && paddr1 == 8'h80) ? sts_q & ~pwdata1[SW-1:0] : sts_q) | set_ev;
        if (rd && paddr1 == 8'h80) prdata1[SW-1:0] = sts_q;
        if (rd && paddr1 == 8'h84) prdata1[SW-1:0] = ien_q;
    end

    always_comb begin
        interrupt1 = '0;
        for (int c = 0; c < NUM_CH; c++) interrupt1[c] = |(sts_q[2*c +: 2] & ien_q[2*c +: 2]);
    end

    always_ff @(posedge pclk1 or posedge p_reset1) begin
        if (p_reset1) begin
            en_q   <= '{default: '0};
            mode_q <= '{default: '0};
            men_q  <= '{default: '0};
            os_q   <= '{default: '0};
            psc_q  <= '{default: '0};
            pcnt_q <= '{default: '0};
            ival_q <= '{default: '0};
            mat_q  <= '{default: '0};
            cnt_q  <= '{default: '0};
            sts_q  <= '0;
            ien_q  <= '0;
        end else begin
            en_q   <= en_d;
            mode_q <= mode_d;
            men_q  <= men_d;
            os_q   <= os_d;
            psc_q  <= psc_d;
            pcnt_q <= pcnt_d;
            ival_q <= ival_d;
            mat_q  <= mat_d;
            cnt_q  <= cnt_d;
            sts_q  <= sts_d;
            ien_q  <= ien_d;
        end
    end
endmodule
